// File: rtl/rv32m_divider.sv
// rv32m_divider: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on magnitudes for WIDTH cycles, then applies the RV32M sign rules.
module rv32m_divider #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG =
      {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic             op_rem;
   logic             is_signed;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] b_mag;
   logic [CW-1:0]    cnt;

   logic             in_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic             div_zero;
   logic             ovf;
   logic             special;
   logic [WIDTH-1:0] spec_q;
   logic [WIDTH-1:0] spec_r;
   logic [WIDTH-1:0] spec_res;
   logic             accept;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] res_fin;

   // operand decode at issue: magnitudes and the two short-cut cases
   assign in_signed = ~i_op[0];
   assign a_neg     = in_signed & i_a[WIDTH-1];
   assign b_neg     = in_signed & i_b[WIDTH-1];
   assign a_abs     = a_neg ? (~i_a + 1'b1) : i_a;
   assign b_abs     = b_neg ? (~i_b + 1'b1) : i_b;
   assign div_zero  = (i_b == '0);
   assign ovf       = in_signed & (i_a == MIN_NEG) & (i_b == '1);
   assign special   = div_zero | ovf;
   assign spec_q    = div_zero ? '1 : MIN_NEG;
   assign spec_r    = div_zero ? i_a : '0;
   assign spec_res  = i_op[1] ? spec_r : spec_q;

   // a new op may enter whenever the unit is not iterating
   assign accept = i_start & ~i_flush & (state != CALC);

   // one restoring step: shift in next dividend bit, try to subtract
   assign rem_sh  = {rem, quo[WIDTH-1]};
   assign trial   = rem_sh - {1'b0, b_mag};
   assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0]
                                 : trial[WIDTH-1:0];
   assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

   // sign fix-up on the value produced by the final step
   assign q_fix   = (is_signed & (sign_a ^ sign_b)) ?
                    (~quo_nxt + 1'b1) : quo_nxt;
   assign r_fix   = (is_signed & sign_a) ?
                    (~rem_nxt + 1'b1) : rem_nxt;
   assign res_fin = op_rem ? r_fix : q_fix;

   // control FSM with registered busy/valid/result
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         o_busy    <= 1'b0;
         o_valid   <= 1'b0;
         o_result  <= '0;
         op_rem    <= 1'b0;
         is_signed <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         b_mag     <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               state   <= IDLE;
               o_busy  <= 1'b0;
               o_valid <= 1'b0;
               if (accept) begin
                  op_rem    <= i_op[1];
                  is_signed <= in_signed;
                  sign_a    <= i_a[WIDTH-1];
                  sign_b    <= i_b[WIDTH-1];
                  rem       <= '0;
                  quo       <= a_abs;
                  b_mag     <= b_abs;
                  cnt       <= CW'(WIDTH-1);
                  if (special) begin
                     state    <= DONE;
                     o_valid  <= 1'b1;
                     o_result <= spec_res;
                  end else begin
                     state  <= CALC;
                     o_busy <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (i_flush) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else begin
                  rem <= rem_nxt;
                  quo <= quo_nxt;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     state    <= DONE;
                     o_busy   <= 1'b0;
                     o_valid  <= 1'b1;
                     o_result <= res_fin;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               o_busy  <= 1'b0;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32m_divider.sv
// tb_rv32m_divider: randomized + directed bench for rv32m_divider.
// Scoreboard queue filled at issue, drained by a monitor on o_valid.
module tb_rv32m_divider;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_start = 1'b0;
   logic [1:0]       i_op = 2'b00;
   logic [WIDTH-1:0] i_a = '0;
   logic [WIDTH-1:0] i_b = '0;
   logic             i_flush = 1'b0;
   logic             o_busy;
   logic             o_valid;
   logic [WIDTH-1:0] o_result;

   rv32m_divider #(.WIDTH(WIDTH)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_start  (i_start),
      .i_op     (i_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_flush  (i_flush),
      .o_busy   (o_busy),
      .o_valid  (o_valid),
      .o_result (o_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       nm;
   } exp_t;

   exp_t        exp_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] last_res = '0;

   // reference: RV32M rules expressed with plain integer arithmetic
   function automatic logic [32:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] q, r;
      logic        sp;
      int          sa, sb;
      sp = 1'b0;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; sp = 1'b1;
      end else if (!op[0] && a == 32'h8000_0000 &&
                   b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0; sp = 1'b1;
      end else if (!op[0]) begin
         sa = a; sb = b;
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {sp, (op[1] ? r : q)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // monitor: every o_valid must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && o_valid) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_valid: got result %h at cycle %0d want no valid",
                     o_result, cyc);
         end else begin
            e = exp_q.pop_front();
            total_cnt++;
            if (o_result === e.res) pass_cnt++;
            else $display("FAIL %s result: got %h want %h",
                          e.nm, o_result, e.res);
            total_cnt++;
            if (cyc == e.cyc) pass_cnt++;
            else $display("FAIL %s latency: got cycle %0d want %0d",
                          e.nm, cyc, e.cyc);
            last_res = e.res;
         end
      end
   end

   // drive an op in the current cycle and record the expectation
   task automatic push_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string nm,
                          output bit sp);
      logic [32:0] m;
      exp_t        e;
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      m = model(op, a, b);
      sp = m[32];
      e.res = m[31:0];
      e.cyc = cyc + 1 + (sp ? 0 : WIDTH);
      e.nm  = nm;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string nm,
                        output bit sp);
      @(negedge clk);
      push_op(op, a, b, nm, sp);
   endtask

   // wait for the scoreboard to empty while counting busy cycles
   task automatic drain(input bit sp, input string nm,
                        input int glitch);
      int nb;
      bit done;
      nb = 0;
      done = 1'b0;
      for (int k = 0; k < 80 && !done; k++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (k == glitch) begin
            i_start = 1'b1;
            i_a = $urandom;
            i_b = $urandom;
         end
         #1;
         if (o_busy) nb++;
         if (exp_q.size() == 0) done = 1'b1;
      end
      i_start = 1'b0;
      if (!done) begin
         total_cnt++;
         $display("FAIL %s timeout: got no valid want valid", nm);
         exp_q.delete();
      end
      chk({nm, " busy_cycles"}, 32'(nb), sp ? 32'd0 : 32'(WIDTH));
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input string nm);
      bit sp;
      issue(op, a, b, nm, sp);
      drain(sp, nm, -1);
   endtask

   // second op issued in the DONE cycle of the first
   task automatic b2b(input logic [1:0] op1, input logic [31:0] a1,
                      input logic [31:0] b1, input logic [1:0] op2,
                      input logic [31:0] a2, input logic [31:0] b2,
                      input string nm);
      bit sp1, sp2, found;
      issue(op1, a1, b1, {nm, "_first"}, sp1);
      found = 1'b0;
      for (int k = 0; k < 80 && !found; k++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (o_valid) found = 1'b1;
      end
      if (!found) begin
         total_cnt++;
         $display("FAIL %s timeout: got no first valid want valid", nm);
         exp_q.delete();
      end else begin
         push_op(op2, a2, b2, {nm, "_second"}, sp2);
         drain(sp2, nm, -1);
      end
   endtask

   function automatic logic [31:0] pick_operand(input int sel);
      unique case (sel)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return $urandom_range(0, 20);
         4: return 32'(-$urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int s0;
      bit sp;
      logic [1:0] op;
      logic [31:0] a, b;

      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_result", o_result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(2'b01, 32'd100, 32'd7, "divu_100_7");
      run(2'b11, 32'd100, 32'd7, "remu_100_7");
      run(2'b00, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
      run(2'b10, 32'hFFFF_FF9C, 32'd7, "rem_m100_7");
      run(2'b10, 32'd100, 32'hFFFF_FFF9, "rem_100_m7");
      run(2'b01, 32'd123, 32'd0, "divu_by0");
      run(2'b00, 32'd123, 32'd0, "div_by0");
      run(2'b10, 32'hFFFF_FFFB, 32'd0, "rem_m5_by0");
      run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovf_ops");

      // start ignored while busy
      issue(2'b01, 32'd77, 32'd7, "divu_ignored_start", sp);
      drain(sp, "divu_ignored_start", 5);

      // flush in cycle 10, restart in cycle 12
      @(negedge clk);
      i_start = 1'b1; i_op = 2'b01; i_a = 32'd1000; i_b = 32'd10;
      s0 = cyc + 1;
      while (cyc < s0 + 9) begin
         @(negedge clk);
         i_start = 1'b0;
         if (cyc == s0 + 4) begin
            i_start = 1'b1; i_a = 32'd7; i_b = 32'd1;
         end
      end
      i_start = 1'b0;
      i_flush = 1'b1;
      chk("flush_busy_before", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      i_flush = 1'b0;
      chk("flush_busy_after", {31'd0, o_busy}, 32'd0);
      chk("flush_no_valid", {31'd0, o_valid}, 32'd0);
      chk("flush_result_held", o_result, last_res);
      run(2'b01, 32'd50, 32'd5, "divu_after_flush");

      // start together with flush in IDLE is dropped
      @(negedge clk);
      i_start = 1'b1; i_flush = 1'b1; i_op = 2'b01;
      i_a = 32'd9; i_b = 32'd0;
      @(negedge clk);
      i_start = 1'b0; i_flush = 1'b0;
      chk("flush_idle_busy", {31'd0, o_busy}, 32'd0);
      chk("flush_idle_valid", {31'd0, o_valid}, 32'd0);

      b2b(2'b01, 32'd81, 32'd4, 2'b01, 32'd9, 32'd3, "b2b_divu");
      b2b(2'b01, 32'd5, 32'd0, 2'b10, 32'hFFFF_FFF0, 32'd3,
          "b2b_special");

      // asynchronous reset mid-CALC
      @(negedge clk);
      i_start = 1'b1; i_op = 2'b01; i_a = 32'd12345; i_b = 32'd3;
      repeat (10) begin
         @(negedge clk);
         i_start = 1'b0;
      end
      chk("pre_reset_busy", {31'd0, o_busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_busy", {31'd0, o_busy}, 32'd0);
      chk("async_reset_valid", {31'd0, o_valid}, 32'd0);
      chk("async_reset_result", o_result, 32'd0);
      last_res = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", {31'd0, o_busy}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = pick_operand($urandom_range(0, 9));
         b = pick_operand($urandom_range(0, 9));
         issue(op, a, b, "rnd", sp);
         drain(sp, "rnd",
               (!sp && $urandom_range(0, 3) == 0) ? 5 : -1);
      end

      for (int i = 0; i < 10; i++) begin
         b2b(2'($urandom_range(0, 3)),
             pick_operand($urandom_range(0, 9)),
             pick_operand($urandom_range(0, 9)),
             2'($urandom_range(0, 3)),
             pick_operand($urandom_range(0, 9)),
             pick_operand($urandom_range(0, 9)), "rnd_b2b");
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
